// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, IR field and fetch-state definitions
package cpu_pkg;

  // Opcodes the fetch stage cares about, plus the branch family the controller decodes
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_JZR  = 4'b1001;
  localparam logic [3:0] OP_JZI  = 4'b1010;
  localparam logic [3:0] OP_JCR  = 4'b1011;
  localparam logic [3:0] OP_JCI  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // IR layout: opcode in the top nibble, immediate in the bottom nibble
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC selection with strobe priority
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  reg_data,
  input  logic             load_pc,
  input  logic             inc_pc,
  input  logic             load_ir,
  input  logic             sel_pc,
  output logic [PC_W-1:0]  next_pc,
  output logic             step
);

  // Branch beats increment beats plain refetch; increment wraps naturally
  always_comb begin
    next_pc = pc;
    step    = load_pc | inc_pc | load_ir;
    if (load_pc) begin
      next_pc = sel_pc ? PC_W'(imm) : reg_data;
    end else if (inc_pc) begin
      next_pc = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage owning PC and IR with timeout detection
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IW       = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              FETCH_TO = 15
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            LoadIR,
  input  logic            IncPC,
  input  logic            SelPC,
  input  logic            LoadPC,
  input  logic [PC_W-1:0] RegData,
  output logic            ImemReq,
  output logic [PC_W-1:0] ImemAddr,
  input  logic            ImemValid,
  input  logic [IW-1:0]   ImemData,
  output logic [3:0]      Opcode,
  output logic [3:0]      Imm,
  output logic            IrValid,
  output logic [PC_W-1:0] PC,
  output logic            FetchErr
);

  // Last wait cycle index: the FETCH_TO-th cycle without data times out
  localparam logic [7:0] TO_LAST = 8'(FETCH_TO - 1);

  fetch_state_t    state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx, pc_target;
  logic [IW-1:0]   ir_q, ir_nx;
  logic [7:0]      cnt_q, cnt_nx;
  logic            err_q, err_nx;
  logic            armed_q;
  logic            step;
  logic [OPC_W-1:0] ir_opc;
  logic [IMM_W-1:0] ir_imm;

  assign ir_opc = ir_q[IW-1 -: OPC_W];
  assign ir_imm = ir_q[IMM_LSB +: IMM_W];

  pc_next_logic #(.PC_W(PC_W)) u_pc_next (
    .pc       (pc_q),
    .imm      (ir_imm),
    .reg_data (RegData),
    .load_pc  (LoadPC),
    .inc_pc   (IncPC),
    .load_ir  (LoadIR),
    .sel_pc   (SelPC),
    .next_pc  (pc_target),
    .step     (step)
  );

  // Fetch FSM next state; armed_q keeps the request low for one cycle after CLR
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    ir_nx    = ir_q;
    cnt_nx   = cnt_q;
    err_nx   = err_q;
    case (state)
      ST_FETCH: begin
        cnt_nx = '0;
        if (armed_q) begin
          if (ImemValid) begin
            ir_nx    = ImemData;
            state_nx = ST_READY;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (ImemValid) begin
          ir_nx    = ImemData;
          state_nx = ST_READY;
        end else if (cnt_q == TO_LAST) begin
          ir_nx    = '0;
          err_nx   = 1'b1;
          state_nx = ST_READY;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      ST_READY: begin
        if (step) begin
          pc_nx    = pc_target;
          state_nx = ST_FETCH;
        end else if (ir_opc == OP_HALT) begin
          state_nx = ST_HALT;
        end
      end
      default: begin
        state_nx = ST_HALT;
      end
    endcase
  end

  // State, PC, IR, timeout counter and sticky error register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      ir_q    <= ir_nx;
      cnt_q   <= cnt_nx;
      err_q   <= err_nx;
      armed_q <= 1'b1;
    end
  end

  assign ImemReq  = armed_q && ((state == ST_FETCH) || (state == ST_WAIT));
  assign ImemAddr = pc_q;
  assign IrValid  = (state == ST_READY) || (state == ST_HALT);
  assign Opcode   = IrValid ? ir_opc : OP_NOP;
  assign Imm      = IrValid ? ir_imm : '0;
  assign PC       = pc_q;
  assign FetchErr = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       LoadIR, IncPC, SelPC, LoadPC;
  logic [7:0] RegData;
  logic       ImemReq;
  logic [7:0] ImemAddr;
  logic       ImemValid = 1'b0;
  logic [7:0] ImemData = 8'hEE;
  logic [3:0] Opcode, Imm;
  logic       IrValid;
  logic [7:0] PC;
  logic       FetchErr;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(
    .PC_W(8), .IW(8), .RESET_PC(8'h00), .FETCH_TO(15)
  ) dut (
    .CLK(CLK), .CLR(CLR), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .RegData(RegData), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemValid(ImemValid), .ImemData(ImemData), .Opcode(Opcode), .Imm(Imm),
    .IrValid(IrValid), .PC(PC), .FetchErr(FetchErr)
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ir;
    logic       err;
  } exp_t;

  localparam int NEVER = 1000;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mem [256];
  int         lat = 1;
  int         req_cycles = 0;
  int         checks = 0;
  int         errors = 0;
  logic       prev_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: data returns on request cycle lat+1 (lat=0 answers in FETCH)
  always @(negedge CLK) begin
    if (ImemReq) req_cycles++;
    else req_cycles = 0;
    ImemValid = ImemReq && (req_cycles == lat + 1);
    ImemData  = ImemValid ? mem[ImemAddr] : 8'hEE;
  end

  // Monitor: every new live instruction is checked against the oldest expectation
  always @(negedge CLK) begin
    if (IrValid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got IR valid at PC %0h expected no fetch", PC);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pc", 32'(PC), 32'(mon_e.pc));
        check("sb_opcode", 32'(Opcode), 32'(mon_e.ir[7:4]));
        check("sb_imm", 32'(Imm), 32'(mon_e.ir[3:0]));
        check("sb_err", 32'(FetchErr), 32'(mon_e.err));
      end
    end
    prev_v = IrValid;
  end

  task automatic wait_ready(input string name, input int exp_req);
    int n = 0;
    int reqs = 0;
    while (!IrValid && n < 60) begin
      if (ImemReq) reqs++;
      check({name, "_nop"}, 32'({Opcode, Imm}), 32'h0);
      @(negedge CLK);
      n++;
    end
    if (!IrValid) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: got no IrValid after %0d cycles expected IrValid", name, n);
    end
    check({name, "_req_cycles"}, 32'(reqs), 32'(exp_req));
  endtask

  task automatic step(input string name, input logic lpc, input logic inc, input logic lir,
                      input logic sel, input logic [7:0] rd, input logic [7:0] exp_pc,
                      input logic [7:0] exp_ir, input logic exp_err, input int exp_req);
    exp_t e;
    e.pc = exp_pc;
    e.ir = exp_ir;
    e.err = exp_err;
    sb.push_back(e);
    LoadPC = lpc; IncPC = inc; LoadIR = lir; SelPC = sel; RegData = rd;
    @(negedge CLK);
    LoadPC = 1'b0; IncPC = 1'b0; LoadIR = 1'b0; SelPC = 1'b0;
    wait_ready(name, exp_req);
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] p, input logic [7:0] ir, input logic err);
    exp_t e;
    e.pc = p;
    e.ir = ir;
    e.err = err;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    CLR = 1'b1; LoadIR = 1'b0; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0; RegData = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h1A; mem[8'h01] = 8'h75; mem[8'h02] = 8'h5D; mem[8'h04] = 8'h6B;
    mem[8'h05] = 8'h2C; mem[8'h0E] = 8'h81; mem[8'h0F] = 8'h96; mem[8'h3C] = 8'h4E;
    mem[8'h40] = 8'hF0; mem[8'hFF] = 8'h33;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check("rst_pc", 32'(PC), 32'h00);
    check("rst_irvalid", 32'(IrValid), 32'h0);
    check("rst_req", 32'(ImemReq), 32'h0);
    check("rst_err", 32'(FetchErr), 32'h0);
    push_exp(8'h00, 8'h1A, 1'b0);
    CLR = 1'b0;
    @(negedge CLK);
    check("boot_req", 32'(ImemReq), 32'h1);
    check("boot_addr", 32'(ImemAddr), 32'h00);
    wait_ready("boot", 2);

    // Sequential, branch and priority steps with a 1-cycle memory
    step("inc",        0, 1, 0, 0, 8'h00, 8'h01, 8'h75, 0, 2);
    step("br_imm",     1, 0, 0, 1, 8'h00, 8'h05, 8'h2C, 0, 2);
    step("br_reg",     1, 0, 0, 0, 8'h3C, 8'h3C, 8'h4E, 0, 2);
    step("br_over_inc",1, 1, 0, 1, 8'h00, 8'h0E, 8'h81, 0, 2);
    step("refetch",    0, 0, 1, 0, 8'h00, 8'h0E, 8'h81, 0, 2);
    step("inc_over_ir",0, 1, 1, 0, 8'h00, 8'h0F, 8'h96, 0, 2);
    step("to_ff",      1, 0, 0, 0, 8'hFF, 8'hFF, 8'h33, 0, 2);
    step("wrap",       0, 1, 0, 0, 8'h00, 8'h00, 8'h1A, 0, 2);

    // Data in the FETCH cycle, then a 6-cycle stall
    lat = 0;
    step("fast",       0, 1, 0, 0, 8'h00, 8'h01, 8'h75, 0, 1);
    lat = 6;
    step("stall",      0, 1, 0, 0, 8'h00, 8'h02, 8'h5D, 0, 7);

    // Timeout, then sticky error survives a good fetch
    lat = NEVER;
    step("timeout",    0, 1, 0, 0, 8'h00, 8'h03, 8'h00, 1, 16);
    check("to_irvalid", 32'(IrValid), 32'h1);
    lat = 1;
    step("sticky",     0, 1, 0, 0, 8'h00, 8'h04, 8'h6B, 1, 2);

    // Data in the last wait cycle beats the timeout
    do_reset();
    lat = 15;
    push_exp(8'h00, 8'h1A, 1'b0);
    wait_ready("to_edge", 16);

    // Halt: PC frozen while strobes toggle
    lat = 1;
    step("to_halt",    1, 0, 0, 0, 8'h40, 8'h40, 8'hF0, 0, 2);
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      LoadPC  = 1'($urandom_range(0, 1));
      IncPC   = 1'($urandom_range(0, 1));
      LoadIR  = 1'($urandom_range(0, 1));
      SelPC   = 1'($urandom_range(0, 1));
      RegData = 8'($urandom);
      @(negedge CLK);
      check("halt_pc", 32'(PC), 32'h40);
      check("halt_state", 32'({IrValid, ImemReq, Opcode}), 32'h2F);
    end
    LoadPC = 1'b0; IncPC = 1'b0; LoadIR = 1'b0; SelPC = 1'b0;

    // CLR during WAIT
    do_reset();
    push_exp(8'h00, 8'h1A, 1'b0);
    wait_ready("post_halt", 2);
    lat = NEVER;
    IncPC = 1'b1;
    @(negedge CLK);
    IncPC = 1'b0;
    repeat (3) @(negedge CLK);
    check("wait_req", 32'(ImemReq), 32'h1);
    check("wait_addr", 32'(ImemAddr), 32'h01);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("clr_req", 32'(ImemReq), 32'h0);
    check("clr_pc", 32'(PC), 32'h00);
    check("clr_irvalid", 32'(IrValid), 32'h0);
    lat = 1;
    push_exp(8'h00, 8'h1A, 1'b0);
    wait_ready("after_clr", 2);

    @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
